ps2_key_event_decoder: RTL and testbench

Sits directly downstream of the PS/2 byte receiver. Consumes validated scan-code bytes, one strobe per byte, and resolves the set-2 prefix bytes E0 (extended), F0 (break) and E1 (pause) into single key events. Events are buffered in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake toward the application logic. It also maintains a held-key bitmap for the 12 note keys Q A W S E D R F T G Y H.

---
 rtl/ps2_key_event_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder
//   Turns a stream of validated PS/2 set-2 scan-code bytes into single key
//   events. Prefix bytes E0 (extended), F0 (break) and E1 (pause) are folded
//   into the event flags. Events wait in a first-word-fall-through FIFO that
//   the consumer drains with a valid/ready handshake. A bitmap tracks which
//   of the 12 note keys are currently held.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   BYTE_IN[7:0]      scan-code byte, qualified by BYTE_VALID
//   BYTE_VALID        one-cycle strobe, byte present
//   BYTE_ERR          byte failed parity/framing (only meaningful with BYTE_VALID)
//   EVT_CODE[7:0]     head event scan code, prefixes stripped
//   EVT_EXT           head event was E0-prefixed
//   EVT_BREAK         head event is a key release
//   EVT_VALID         FIFO not empty
//   EVT_READY         consumer pops the head when EVT_VALID && EVT_READY
//   KEY_HELD[11:0]    held bitmap: Q A W S E D R F T G Y H (bit0..bit11)
//   OVERFLOW          sticky: an event was dropped on a full FIFO
//   ERR_CNT[7:0]      saturating count of erroneous bytes
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 2500000,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    input  logic        BYTE_ERR,
    output logic [7:0]  EVT_CODE,
    output logic        EVT_EXT,
    output logic        EVT_BREAK,
    output logic        EVT_VALID,
    input  logic        EVT_READY,
    output logic [11:0] KEY_HELD,
    output logic        OVERFLOW,
    output logic [7:0]  ERR_CNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;

    // Bytes that are keyboard replies/status rather than scan codes.
    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    // {hit, bitmap index} for the note keys.
    function automatic logic [4:0] key_index(input logic [7:0] code);
        case (code)
            8'h15: return 5'h10;
            8'h1C: return 5'h11;
            8'h1D: return 5'h12;
            8'h1B: return 5'h13;
            8'h24: return 5'h14;
            8'h23: return 5'h15;
            8'h2D: return 5'h16;
            8'h2B: return 5'h17;
            8'h2C: return 5'h18;
            8'h34: return 5'h19;
            8'h35: return 5'h1A;
            8'h33: return 5'h1B;
            default: return 5'h00;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [11:0]   held_q, held_d;
    logic          overflow_q, overflow_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];

    logic          dec_vld, dec_ext, dec_brk;
    logic          push_req, push_ok, pop, full;
    logic [4:0]    key;
    logic [9:0]    head;

    // Prefix FSM, timeout and error counting.
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        tmo_d     = tmo_q;
        err_cnt_d = err_cnt_q;
        dec_vld   = 1'b0;
        dec_ext   = 1'b0;
        dec_brk   = 1'b0;
        if (BYTE_VALID) begin
            tmo_d = '0;
            if (BYTE_ERR) begin
                state_d = IDLE;
                skip_d  = '0;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else if (state_q == PAUSE) begin
                // The pause sequence is opaque: count bytes, emit nothing.
                if (skip_q <= 3'd1) begin
                    state_d = IDLE;
                    skip_d  = '0;
                end else begin
                    skip_d = skip_q - 3'd1;
                end
            end else if (is_ctrl(BYTE_IN)) begin
                state_d = IDLE;
            end else if (BYTE_IN == 8'hE0) begin
                // Also restarts a stale prefix, as if seen in IDLE.
                state_d = EXT;
            end else if (BYTE_IN == 8'hE1) begin
                state_d = PAUSE;
                skip_d  = 3'd7;
            end else if (BYTE_IN == 8'hF0 && state_q == IDLE) begin
                state_d = BRK;
            end else if (BYTE_IN == 8'hF0 && state_q == EXT) begin
                state_d = EXTBRK;
            end else begin
                dec_vld = 1'b1;
                dec_ext = (state_q == EXT) || (state_q == EXTBRK);
                dec_brk = (state_q == BRK) || (state_q == EXTBRK);
                state_d = IDLE;
            end
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = IDLE;
                skip_d  = '0;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Held bitmap and repeat suppression; the bitmap tracks the keyboard
    // even when the FIFO drops the event.
    always_comb begin
        key      = key_index(BYTE_IN);
        held_d   = held_q;
        push_req = dec_vld;
        if (dec_vld && key[4] && !dec_ext) begin
            if (dec_brk) begin
                held_d[key[3:0]] = 1'b0;
            end else begin
                if (SUPPRESS_REPEAT != 0 && held_q[key[3:0]]) push_req = 1'b0;
                held_d[key[3:0]] = 1'b1;
            end
        end
    end

    // FWFT FIFO. A pop frees a slot for a same-cycle push when full; an
    // empty FIFO never pops, so a simultaneous push simply lands.
    always_comb begin
        full    = (count_q == CNT_FULL);
        pop     = (count_q != '0) && EVT_READY;
        push_ok = push_req && (!full || pop);
        mem_d   = mem_q;
        if (push_ok) mem_d[wptr_q] = {dec_ext, dec_brk, BYTE_IN};
        wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (!push_ok && pop) count_d = count_q - (AW + 1)'(1);
        overflow_d = overflow_q || (push_req && !push_ok);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            skip_q     <= '0;
            tmo_q      <= '0;
            err_cnt_q  <= '0;
            held_q     <= '0;
            overflow_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            tmo_q      <= tmo_d;
            err_cnt_q  <= err_cnt_d;
            held_q     <= held_d;
            overflow_q <= overflow_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through a non-zero count.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    // Head fields are forced to zero when empty so reset shows all zeros.
    always_comb begin
        head      = mem_q[rptr_q];
        EVT_VALID = (count_q != '0);
        EVT_CODE  = EVT_VALID ? head[7:0] : 8'h00;
        EVT_BREAK = EVT_VALID ? head[8]   : 1'b0;
        EVT_EXT   = EVT_VALID ? head[9]   : 1'b0;
        KEY_HELD  = held_q;
        OVERFLOW  = overflow_q;
        ERR_CNT   = err_cnt_q;
    end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder: stimulus pushes expected
// events {ext, brk, code}; a monitor pops and compares on each handshake.
module tb_ps2_key_event_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  BYTE_IN = 8'h00;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_ERR = 1'b0;
    logic [7:0]  EVT_CODE;
    logic        EVT_EXT;
    logic        EVT_BREAK;
    logic        EVT_VALID;
    logic        EVT_READY = 1'b0;
    logic [11:0] KEY_HELD;
    logic        OVERFLOW;
    logic [7:0]  ERR_CNT;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [9:0] exp_q [$];

    ps2_key_event_decoder #(
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(16),
        .SUPPRESS_REPEAT(1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_ERR(BYTE_ERR),
        .EVT_CODE(EVT_CODE), .EVT_EXT(EVT_EXT), .EVT_BREAK(EVT_BREAK),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
        .KEY_HELD(KEY_HELD), .OVERFLOW(OVERFLOW), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        @(negedge CLK);
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        BYTE_ERR   = err;
        @(posedge CLK);
        #1;
        BYTE_VALID = 1'b0;
        BYTE_ERR   = 1'b0;
    endtask

    // Send a byte expected to produce event {ext, brk, b}.
    task automatic send_evt(input logic [7:0] b, input logic ext, input logic brk);
        exp_q.push_back({ext, brk, b});
        send(b);
    endtask

    task automatic set_ready(input logic v);
        @(posedge CLK);
        #1;
        EVT_READY = v;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLK);
        check({name, "_drain"}, exp_q.size(), 0);
        @(posedge CLK);
        #1;
        check({name, "_empty"}, EVT_VALID, 0);
    endtask

    // Monitor: a pop happens at the next edge whenever valid and ready.
    always @(negedge CLK) begin
        if (!RST && EVT_VALID && EVT_READY) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL evt_unexpected: got code %0h ext %0d brk %0d expected no event",
                         EVT_CODE, EVT_EXT, EVT_BREAK);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({EVT_EXT, EVT_BREAK, EVT_CODE} !== e) begin
                    n_fail++;
                    $display("FAIL evt: got code %0h ext %0d brk %0d expected code %0h ext %0d brk %0d",
                             EVT_CODE, EVT_EXT, EVT_BREAK, e[7:0], e[9], e[8]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] rel [6];
        logic [7:0] pause_seq [8];
        rel = '{8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23};
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", EVT_VALID, 0);
        check("rst_held", KEY_HELD, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_err", ERR_CNT, 0);
        @(negedge CLK);
        RST = 1'b0;
        set_ready(1'b1);

        // Basic make / break
        send_evt(8'h15, 0, 0);
        check("make_latency", EVT_VALID, 1);
        check("make_held", KEY_HELD, 12'h001);
        send(8'hF0);
        send_evt(8'h15, 0, 1);
        check("brk_latency", EVT_VALID, 1);
        check("brk_held", KEY_HELD, 12'h000);
        wait_drain("basic");

        // Extended keys and control bytes
        send(8'hE0);
        send_evt(8'h75, 1, 0);
        send(8'hE0);
        send(8'hF0);
        send_evt(8'h75, 1, 1);
        check("ext_held", KEY_HELD, 12'h000);
        send(8'hAA);
        send(8'hFA);
        wait_drain("ext");

        // Overflow and repeat suppression (Q held beforehand)
        send_evt(8'h15, 0, 0);
        wait_drain("preq");
        set_ready(1'b0);
        send_evt(8'h1C, 0, 0);
        send(8'h1C);
        send_evt(8'h1D, 0, 0);
        send_evt(8'h1B, 0, 0);
        send_evt(8'h24, 0, 0);
        check("ovf_clear", OVERFLOW, 0);
        send(8'h23);
        check("ovf_set", OVERFLOW, 1);
        check("ovf_held", KEY_HELD, 12'h03F);
        check("ovf_valid", EVT_VALID, 1);
        set_ready(1'b1);
        wait_drain("ovf");
        check("ovf_sticky", OVERFLOW, 1);

        // Release everything
        foreach (rel[i]) begin
            send(8'hF0);
            send_evt(rel[i], 0, 1);
        end
        check("rel_held", KEY_HELD, 12'h000);
        wait_drain("rel");

        // Pause sequence
        foreach (pause_seq[i]) send(pause_seq[i]);
        send_evt(8'h2C, 0, 0);
        check("pause_held", KEY_HELD, 12'h100);
        send(8'hF0);
        send_evt(8'h2C, 0, 1);
        wait_drain("pause");

        // Error byte abandons the break prefix
        send(8'hF0);
        send(8'h15, 1'b1);
        check("err_cnt", ERR_CNT, 1);
        send_evt(8'h15, 0, 0);
        check("err_held", KEY_HELD, 12'h001);
        send(8'hF0);
        send_evt(8'h15, 0, 1);
        wait_drain("err");

        // Timeout abandons the break prefix
        send(8'hF0);
        repeat (20) @(posedge CLK);
        send_evt(8'h15, 0, 0);
        check("tmo_held", KEY_HELD, 12'h001);
        send(8'hF0);
        send_evt(8'h15, 0, 1);
        wait_drain("tmo");

        // Reset mid-prefix with a non-empty FIFO
        set_ready(1'b0);
        send_evt(8'h34, 0, 0);
        send(8'hE0);
        send(8'hF0);
        check("prerst_held", KEY_HELD, 12'h200);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.delete();
        check("mrst_valid", EVT_VALID, 0);
        check("mrst_code", {EVT_EXT, EVT_BREAK, EVT_CODE}, 0);
        check("mrst_held", KEY_HELD, 0);
        check("mrst_ovf", OVERFLOW, 0);
        check("mrst_err", ERR_CNT, 0);
        @(negedge CLK);
        RST = 1'b0;
        set_ready(1'b1);
        send_evt(8'h75, 0, 0);
        wait_drain("mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
